pipe_perf_monitor: RTL and testbench

Synthesizable, parametrised event monitor for the pipelined CPU. It replaces the per-cycle simulation printouts (stall, branch squash, jump squash, forwarding paths) with hardware counters and a trace FIFO. It sits beside the CPU top level, samples one-cycle event strobes from the ID/EX/MEM/WB control logic and records them. Counters and trace are readable through a registered read port and a valid/ready trace pop interface.

---
 rtl/pipe_perf_monitor_if.sv | 25 ++
 rtl/pipe_perf_monitor.sv | 153 +++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_perf_monitor_if.sv
// Trace pop channel of the pipeline performance monitor: valid/ready handshake
// carrying the captured PC and event vector of the FIFO head.
interface pipe_perf_monitor_if #(
    parameter int NUM_EVT = 8,
    parameter int PC_W    = 32
);
    logic                tr_valid;
    logic                tr_ready;
    logic [PC_W-1:0]     tr_pc;
    logic [NUM_EVT-1:0]  tr_evt;

    modport master (
        output tr_valid,
        output tr_pc,
        output tr_evt,
        input  tr_ready
    );

    modport slave (
        input  tr_valid,
        input  tr_pc,
        input  tr_evt,
        output tr_ready
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Event counters, cycle counter and first-word-fall-through trace FIFO fed by
// one-cycle pipeline event strobes (stall, squash, forwarding paths).
module pipe_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int NUM_EVT     = 8,
    parameter int PC_W        = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int SATURATE    = 1,
    localparam int SEL_W      = $clog2(NUM_EVT + 1),
    localparam int LVL_W      = $clog2(TRACE_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [NUM_EVT-1:0]   evt_i,
    input  logic [PC_W-1:0]      pc_i,
    input  logic [NUM_EVT-1:0]   trace_mask_i,
    input  logic [SEL_W-1:0]     rd_sel_i,
    output logic [CNT_W-1:0]     rd_data_o,
    output logic [NUM_EVT:0]     cnt_ovf_o,
    output logic                 tr_drop_o,
    output logic [LVL_W-1:0]     tr_level_o,
    pipe_perf_monitor_if.master  tr
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int ENT_W = PC_W + NUM_EVT;

    // ------------------------------------------------------------------
    // Counter bank: index NUM_EVT is the free-running cycle counter.
    // ------------------------------------------------------------------
    logic [NUM_EVT:0]            inc_w;
    logic [NUM_EVT:0][CNT_W-1:0] cnt_q;
    logic [NUM_EVT:0][CNT_W-1:0] cnt_d;
    logic [NUM_EVT:0]            ovf_q;
    logic [NUM_EVT:0]            ovf_d;

    assign inc_w = {en_i, evt_i & {NUM_EVT{en_i}}};

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
            logic at_max;
            assign at_max = &cnt_q[gi];

            // Clear beats a same-cycle increment; the overflow flag is sticky.
            assign cnt_d[gi] = clr_i        ? '0 :
                               !inc_w[gi]   ? cnt_q[gi] :
                               !at_max      ? cnt_q[gi] + CNT_W'(1) :
                               (SATURATE != 0) ? cnt_q[gi] : '0;
            assign ovf_d[gi] = !clr_i & (ovf_q[gi] | (inc_w[gi] & at_max));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_ovf_o = ovf_q;

    // ------------------------------------------------------------------
    // Registered read port; out-of-range selects read as zero.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rd_data_d;
    logic [CNT_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i <= NUM_EVT; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_data_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

    // ------------------------------------------------------------------
    // Trace FIFO control
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             drop_q;
    logic             drop_d;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(TRACE_DEPTH));
    assign push_req = en_i & (|(evt_i & trace_mask_i));
    assign pop      = !empty & tr.tr_ready;
    // A pop frees the head slot at this edge, so a push into a full FIFO still fits.
    assign push     = push_req & (!full | pop);

    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    assign drop_d   = !clr_i & (drop_q | (push_req & !push));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Storage carries no reset; the head outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= {pc_i, evt_i};
        end
    end

    logic [ENT_W-1:0] head_w;
    assign head_w = mem_q[rd_ptr_q];

    assign tr.tr_valid = !empty;
    assign tr.tr_pc    = empty ? '0 : head_w[ENT_W-1:NUM_EVT];
    assign tr.tr_evt   = empty ? '0 : head_w[NUM_EVT-1:0];
    assign tr_level_o  = level_q;
    assign tr_drop_o   = drop_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench: a saturating and a wrapping 4-bit instance share one stimulus stream.
module tb_pipe_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [7:0]  evt;
    logic [31:0] pc;
    logic [7:0]  trace_mask;
    logic [3:0]  rd_sel;
    logic        tr_ready;

    logic [3:0]  rd_data_s, rd_data_w;
    logic [8:0]  ovf_s, ovf_w;
    logic        drop_s, drop_w;
    logic [2:0]  level_s, level_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor_if #(.NUM_EVT(8), .PC_W(32)) if_s ();
    pipe_perf_monitor_if #(.NUM_EVT(8), .PC_W(32)) if_w ();
    assign if_s.tr_ready = tr_ready;
    assign if_w.tr_ready = tr_ready;

    pipe_perf_monitor #(.CNT_W(4), .NUM_EVT(8), .PC_W(32), .TRACE_DEPTH(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .evt_i(evt), .pc_i(pc),
        .trace_mask_i(trace_mask), .rd_sel_i(rd_sel), .rd_data_o(rd_data_s),
        .cnt_ovf_o(ovf_s), .tr_drop_o(drop_s), .tr_level_o(level_s), .tr(if_s)
    );

    pipe_perf_monitor #(.CNT_W(4), .NUM_EVT(8), .PC_W(32), .TRACE_DEPTH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .evt_i(evt), .pc_i(pc),
        .trace_mask_i(trace_mask), .rd_sel_i(rd_sel), .rd_data_o(rd_data_w),
        .cnt_ovf_o(ovf_w), .tr_drop_o(drop_w), .tr_level_o(level_w), .tr(if_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input logic [3:0] exp_s, input logic [3:0] exp_w, input string tag);
        rd_sel = 4'(sel);
        tick();
        chk({tag, "_sat"}, rd_data_s, exp_s);
        chk({tag, "_wrap"}, rd_data_w, exp_w);
        $display("read sel=%0d sat=%0d wrap=%0d", sel, rd_data_s, rd_data_w);
    endtask

    task automatic fifo_chk(input logic [2:0] lvl, input logic drp, input string tag);
        chk({tag, "_level_sat"}, level_s, lvl);
        chk({tag, "_level_wrap"}, level_w, lvl);
        chk({tag, "_drop_sat"}, drop_s, drp);
        chk({tag, "_drop_wrap"}, drop_w, drp);
        $display("fifo %s level=%0d drop=%0d", tag, level_s, drop_s);
    endtask

    task automatic head_chk(input logic [31:0] epc, input logic [7:0] eevt, input string tag);
        chk({tag, "_valid_sat"}, if_s.tr_valid, 1'b1);
        chk({tag, "_valid_wrap"}, if_w.tr_valid, 1'b1);
        chk({tag, "_pc_sat"}, if_s.tr_pc, epc);
        chk({tag, "_pc_wrap"}, if_w.tr_pc, epc);
        chk({tag, "_evt_sat"}, if_s.tr_evt, eevt);
        chk({tag, "_evt_wrap"}, if_w.tr_evt, eevt);
        $display("head %s pc=%0h evt=%0h", tag, if_s.tr_pc, if_s.tr_evt);
    endtask

    task automatic push(input logic [31:0] p, input logic [7:0] e);
        en  = 1'b1;
        evt = e;
        pc  = p;
        tick();
        $display("push pc=%0h evt=%0h level=%0d", p, e, level_s);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; evt = '0; pc = '0;
        trace_mask = '0; rd_sel = '0; tr_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_rd_sat", rd_data_s, 4'd0);
        chk("rst_rd_wrap", rd_data_w, 4'd0);
        chk("rst_ovf_sat", ovf_s, 9'd0);
        chk("rst_ovf_wrap", ovf_w, 9'd0);
        chk("rst_valid", if_s.tr_valid, 1'b0);
        chk("rst_pc", if_s.tr_pc, 32'd0);
        fifo_chk(3'd0, 1'b0, "rst");

        // Idle counting: 10 enabled cycles
        rst = 1'b1; en = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        rd(8, 4'd10, 4'd10, "idle_cycles");
        rd(0, 4'd0, 4'd0, "idle_evt0");
        chk("idle_valid", if_s.tr_valid, 1'b0);

        clr = 1'b1; tick(); clr = 1'b0;
        rd(8, 4'd0, 4'd0, "clr_cycles");

        // Mixed events
        en = 1'b1; evt = 8'b0000_0011;
        repeat (3) tick();
        evt = 8'b0010_0100;
        repeat (2) tick();
        en = 1'b0; evt = '0;
        rd(0, 4'd3, 4'd3, "mix_c0");
        rd(1, 4'd3, 4'd3, "mix_c1");
        rd(2, 4'd2, 4'd2, "mix_c2");
        rd(3, 4'd0, 4'd0, "mix_c3");
        rd(5, 4'd2, 4'd2, "mix_c5");
        rd(7, 4'd0, 4'd0, "mix_c7");
        rd(8, 4'd5, 4'd5, "mix_cycles");
        rd(9, 4'd0, 4'd0, "sel_out_of_range");

        // Clear priority over a same-cycle increment
        en = 1'b1; evt = 8'h02;
        repeat (2) tick();
        en = 1'b0; evt = '0;
        rd(1, 4'd5, 4'd5, "pre_clr_c1");
        clr = 1'b1; en = 1'b1; evt = 8'h02;
        tick();
        chk("clr_edge_shows_pre_value", rd_data_s, 4'd5);
        clr = 1'b0; en = 1'b0; evt = '0;
        tick();
        chk("clr_prio_sat", rd_data_s, 4'd0);
        chk("clr_prio_wrap", rd_data_w, 4'd0);
        $display("clr priority c1 sat=%0d wrap=%0d", rd_data_s, rd_data_w);

        // Saturate vs wrap: 17 increments on 4-bit counters
        en = 1'b1; evt = 8'h01;
        repeat (17) tick();
        en = 1'b0; evt = '0;
        chk("ovf_sat", ovf_s, 9'h101);
        chk("ovf_wrap", ovf_w, 9'h101);
        rd(0, 4'd15, 4'd1, "limit_c0");
        rd(8, 4'd15, 4'd1, "limit_cycles");
        rd(1, 4'd0, 4'd0, "limit_c1");
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr_sat", ovf_s, 9'd0);
        chk("ovf_clr_wrap", ovf_w, 9'd0);

        // Trace ordering and full
        trace_mask = 8'h02;
        push(32'h99, 8'h01);
        fifo_chk(3'd0, 1'b0, "unmasked");
        push(32'h0, 8'h02);
        push(32'h4, 8'h02);
        push(32'h8, 8'h06);
        push(32'hC, 8'h02);
        push(32'h10, 8'h02);
        en = 1'b0; evt = '0;
        fifo_chk(3'd4, 1'b1, "full");
        tr_ready = 1'b1;
        head_chk(32'h0, 8'h02, "pop0"); tick();
        head_chk(32'h4, 8'h02, "pop1"); tick();
        head_chk(32'h8, 8'h06, "pop2"); tick();
        head_chk(32'hC, 8'h02, "pop3"); tick();
        chk("drained_valid", if_s.tr_valid, 1'b0);
        fifo_chk(3'd0, 1'b1, "drained");

        // Concurrent push/pop at full
        tr_ready = 1'b0;
        push(32'h100, 8'h02);
        push(32'h104, 8'h02);
        push(32'h108, 8'h02);
        push(32'h10C, 8'h02);
        en = 1'b0; evt = '0;
        clr = 1'b1; tick(); clr = 1'b0;
        fifo_chk(3'd4, 1'b0, "clr_keeps_fifo");
        tr_ready = 1'b1;
        head_chk(32'h100, 8'h02, "full_pushpop_head");
        push(32'h20, 8'h02);
        en = 1'b0; evt = '0;
        fifo_chk(3'd4, 1'b0, "full_pushpop");
        head_chk(32'h104, 8'h02, "pp0"); tick();
        head_chk(32'h108, 8'h02, "pp1"); tick();
        head_chk(32'h10C, 8'h02, "pp2"); tick();
        head_chk(32'h20, 8'h02, "pp3"); tick();
        chk("pp_drained_valid", if_w.tr_valid, 1'b0);

        // Push with ready on empty, then push/pop at level 1
        push(32'h30, 8'h02);
        fifo_chk(3'd1, 1'b0, "empty_push_pop");
        head_chk(32'h30, 8'h02, "empty_push_head");
        push(32'h34, 8'h02);
        fifo_chk(3'd1, 1'b0, "lvl1_push_pop");
        head_chk(32'h34, 8'h02, "lvl1_head");
        tr_ready = 1'b0;
        push(32'h38, 8'h02);
        push(32'h3C, 8'h02);
        push(32'h40, 8'h02);
        push(32'h44, 8'h02);
        fifo_chk(3'd4, 1'b1, "refill");

        // Reset mid-stream overrides every other input
        rst = 1'b0; en = 1'b1; evt = 8'hFF; clr = 1'b0;
        tick();
        fifo_chk(3'd0, 1'b0, "midrst");
        chk("midrst_valid", if_s.tr_valid, 1'b0);
        chk("midrst_pc", if_w.tr_pc, 32'd0);
        chk("midrst_evt", if_s.tr_evt, 8'd0);
        chk("midrst_ovf", ovf_w, 9'd0);
        chk("midrst_rd", rd_data_s, 4'd0);
        rst = 1'b1; en = 1'b0; evt = '0;
        rd(1, 4'd0, 4'd0, "midrst_c1");
        rd(8, 4'd0, 4'd0, "midrst_cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
